// File: rtl/bldc_pkg.sv
// ============================================================================
//  Module   : bldc_pkg
//  Purpose  : Shared types, defaults and the Hall-to-gate commutation lookup
//  Revision : 1.0
// ============================================================================
`default_nettype none

package bldc_pkg;

  localparam int c_pwm_bits    = 4;
  localparam int c_dead_cycles = 2;

  typedef struct packed {
    logic a;
    logic aa;
    logic b;
    logic bb;
    logic c;
    logic cc;
  } gate_t;

  localparam gate_t c_gates_off = '0;

  // S = {H3,H2,H1}; 000 and 111 are not physical rotor positions and map to all-off.
  function automatic gate_t hall_to_pattern(input logic [2:0] s);
    gate_t p;
    p = c_gates_off;
    case (s)
      3'b001:  begin p.a = 1'b1; p.bb = 1'b1; end
      3'b101:  begin p.a = 1'b1; p.cc = 1'b1; end
      3'b100:  begin p.b = 1'b1; p.cc = 1'b1; end
      3'b110:  begin p.b = 1'b1; p.aa = 1'b1; end
      3'b010:  begin p.c = 1'b1; p.aa = 1'b1; end
      3'b011:  begin p.c = 1'b1; p.bb = 1'b1; end
      default: p = c_gates_off;
    endcase
    return p;
  endfunction

  function automatic gate_t apply_pwm(input gate_t p, input logic pwm);
    gate_t g;
    g    = p;
    g.a  = p.a & pwm;
    g.b  = p.b & pwm;
    g.c  = p.c & pwm;
    return g;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bldc_if.sv
// ============================================================================
//  Module   : bldc_if
//  Purpose  : Hall/duty inputs and six gate outputs of the commutation block
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface bldc_if #(
  parameter int PWM_BITS = bldc_pkg::c_pwm_bits
);
  logic                h1;
  logic                h2;
  logic                h3;
  logic [PWM_BITS-1:0] d;
  logic                a;
  logic                aa;
  logic                b;
  logic                bb;
  logic                c;
  logic                cc;

  modport master (output h1, h2, h3, d, input  a, aa, b, bb, c, cc);
  modport slave  (input  h1, h2, h3, d, output a, aa, b, bb, c, cc);
endinterface

`default_nettype wire

// File: rtl/pwm_gen.sv
// ============================================================================
//  Module   : pwm_gen
//  Purpose  : Free-running PWM counter with period-boundary duty reload
//  Revision : 1.0
// ============================================================================
`default_nettype none

module pwm_gen #(
  parameter int PWM_BITS = 4
) (
  input  wire logic                clk,
  input  wire logic                rst,
  input  wire logic [PWM_BITS-1:0] i_duty,
  output logic                     o_pwm
);

  logic [PWM_BITS-1:0] r_cnt;
  logic [PWM_BITS-1:0] r_duty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_duty <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
      // Reload only on the last count so a period is never truncated or stretched.
      if (r_cnt == '1) begin
        r_duty <= i_duty;
      end
    end
  end

  assign o_pwm = (r_cnt < r_duty);

endmodule

`default_nettype wire

// File: rtl/main_1.sv
// ============================================================================
//  Module   : main_1
//  Purpose  : Six-step BLDC commutation with Hall sync, dead time and PWM
//  Revision : 1.0
// ============================================================================
`default_nettype none

module main_1
  import bldc_pkg::*;
#(
  parameter int PWM_BITS    = c_pwm_bits,
  parameter int DEAD_CYCLES = c_dead_cycles
) (
  input wire logic clk,
  input wire logic rst,
  bldc_if.slave    bus
);

  localparam int c_dw = (DEAD_CYCLES < 1) ? 1 : $clog2(DEAD_CYCLES + 1);

  logic [2:0]      r_meta;
  logic [2:0]      r_sync;
  gate_t           r_applied;
  gate_t           r_out;
  logic [c_dw-1:0] r_dead;
  logic            w_pwm;
  gate_t           w_target;

  pwm_gen #(
    .PWM_BITS (PWM_BITS)
  ) u_pwm (
    .clk    (clk),
    .rst    (rst),
    .i_duty (bus.d),
    .o_pwm  (w_pwm)
  );

  assign w_target = hall_to_pattern(r_sync);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta    <= '0;
      r_sync    <= '0;
      r_applied <= c_gates_off;
      r_dead    <= '0;
      r_out     <= c_gates_off;
    end else begin
      r_meta <= {bus.h3, bus.h2, bus.h1};
      r_sync <= r_meta;
      // A new pattern (re)starts the dead count, even if one is already running.
      if (w_target != r_applied) begin
        r_applied <= w_target;
        r_dead    <= c_dw'(DEAD_CYCLES);
        r_out     <= (DEAD_CYCLES == 0) ? apply_pwm(w_target, w_pwm) : c_gates_off;
      end else if (r_dead != '0) begin
        r_dead <= r_dead - 1'b1;
        r_out  <= (r_dead == c_dw'(1)) ? apply_pwm(r_applied, w_pwm) : c_gates_off;
      end else begin
        r_out <= apply_pwm(r_applied, w_pwm);
      end
    end
  end

  assign bus.a  = r_out.a;
  assign bus.aa = r_out.aa;
  assign bus.b  = r_out.b;
  assign bus.bb = r_out.bb;
  assign bus.c  = r_out.c;
  assign bus.cc = r_out.cc;

endmodule

`default_nettype wire

// File: tb/tb_main_1.sv
// ============================================================================
//  Module   : tb_main_1
//  Purpose  : Directed self-checking bench for the main_1 commutation block
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_main_1;

  logic       clk;
  logic       rst;
  logic [3:0] phase;
  logic [5:0] gates;
  int         n_cmp;
  int         n_err;
  int         n_shoot;
  int         n_multi;

  bldc_if #(.PWM_BITS(4)) bus ();

  main_1 #(
    .PWM_BITS    (4),
    .DEAD_CYCLES (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Bit order {a,aa,b,bb,c,cc}: highs at 5/3/1, lows at 4/2/0.
  assign gates = {bus.a, bus.aa, bus.b, bus.bb, bus.c, bus.cc};

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Expected PWM counter value, used only to align the duty-change window.
  always @(posedge clk) phase <= rst ? 4'd0 : phase + 4'd1;

  always @(negedge clk) begin
    if ((bus.a & bus.aa) | (bus.b & bus.bb) | (bus.c & bus.cc)) n_shoot++;
    if ((32'(bus.a) + 32'(bus.b) + 32'(bus.c) > 1) ||
        (32'(bus.aa) + 32'(bus.bb) + 32'(bus.cc) > 1)) n_multi++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_hall(input logic [2:0] s);
    {bus.h3, bus.h2, bus.h1} = s;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Samples n consecutive clocks and returns on-counts for one high and one low bit plus stray bits.
  task automatic measure(input int n, input int hi, input int lo, input logic [5:0] allowed,
                         output int n_hi, output int n_lo, output logic [5:0] stray);
    n_hi  = 0;
    n_lo  = 0;
    stray = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      n_hi  += int'(gates[hi]);
      n_lo  += int'(gates[lo]);
      stray |= gates & ~allowed;
    end
  endtask

  logic [2:0]  hall_seq [6] = '{3'b001, 3'b101, 3'b100, 3'b110, 3'b010, 3'b011};
  int          hi_bit   [6] = '{5, 5, 3, 3, 1, 1};
  int          lo_bit   [6] = '{2, 0, 0, 4, 4, 2};

  initial begin
    int         nh, nl, lat;
    logic [5:0] stray, acc, z;
    logic [2:0] lo0, lo_new;
    logic [19:0] obs_v, exp_v;

    n_cmp = 0; n_err = 0; n_shoot = 0; n_multi = 0;
    rst = 1'b1; bus.d = 4'd15; set_hall(3'b101);

    // Reset held for 3 clocks with a valid Hall state present.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq($sformatf("reset_off_%0d", i), 32'(gates), 32'd0);
    end
    rst = 1'b0; set_hall(3'b000); bus.d = 4'd10;
    acc = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      acc |= gates;
    end
    check_eq("idle_after_reset", 32'(acc), 32'd0);

    // Full electrical revolution at 10/16 duty, 50 clocks per step.
    for (int s = 0; s < 6; s++) begin
      set_hall(hall_seq[s]);
      ticks(10);
      measure(32, hi_bit[s], lo_bit[s], 6'(1 << hi_bit[s]) | 6'(1 << lo_bit[s]), nh, nl, stray);
      check_eq($sformatf("step%0d_hi_duty", s), 32'(nh), 32'd20);
      check_eq($sformatf("step%0d_lo_solid", s), 32'(nl), 32'd32);
      check_eq($sformatf("step%0d_stray", s), 32'(stray), 32'd0);
      ticks(8);
    end

    // Duty extremes on C/BB.
    bus.d = 4'd0;
    ticks(20);
    measure(32, 1, 2, 6'b000110, nh, nl, stray);
    check_eq("d0_hi", 32'(nh), 32'd0);
    check_eq("d0_lo", 32'(nl), 32'd32);
    bus.d = 4'd15;
    ticks(20);
    measure(32, 1, 2, 6'b000110, nh, nl, stray);
    check_eq("d15_hi", 32'(nh), 32'd30);

    // Duty 15 -> 3 mid-period: old duty finishes the period, new one starts at the wrap.
    lat = 0;
    while (phase != 4'd5 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check_eq("align_phase", 32'(phase), 32'd5);
    for (int i = 0; i < 20; i++) begin
      obs_v[i] = bus.c;
      exp_v[i] = (i < 11) || (i >= 12 && i < 15);
      if (i == 0) bus.d = 4'd3;
      @(negedge clk);
    end
    check_eq("duty_change_at_wrap", 32'(obs_v), 32'(exp_v));

    // Dead time on 001 -> 101.
    bus.d = 4'd15; set_hall(3'b001);
    ticks(40);
    set_hall(3'b101);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      z[i] = (gates == 6'd0);
      if (i == 0) lo0 = {gates[4], gates[2], gates[0]};
      if (i == 4) lo_new = {gates[4], gates[2], gates[0]};
    end
    check_eq("dead_gap", 32'(z), 32'b001100);
    check_eq("dead_old_low", 32'(lo0), 32'b010);
    check_eq("dead_new_low", 32'(lo_new), 32'b001);

    // Second change during dead time restarts the count.
    ticks(20);
    set_hall(3'b100);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      z[i] = (gates == 6'd0);
      if (i == 0) set_hall(3'b110);
      if (i == 5) lo_new = {gates[4], gates[2], gates[0]};
    end
    check_eq("dead_restart_gap", 32'(z), 32'b011100);
    check_eq("dead_restart_low", 32'(lo_new), 32'b100);

    // Invalid Hall states.
    ticks(20);
    set_hall(3'b000);
    ticks(10);
    measure(16, 5, 4, 6'b000000, nh, nl, stray);
    check_eq("hall_000_off", 32'(stray), 32'd0);
    set_hall(3'b111);
    ticks(10);
    measure(16, 5, 4, 6'b000000, nh, nl, stray);
    check_eq("hall_111_off", 32'(stray), 32'd0);
    set_hall(3'b011);
    lat = 0;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      if (gates[2] && lat == 0) lat = k;
    end
    check_eq("recover_latency", 32'(lat), 32'd5);
    measure(16, 1, 2, 6'b000110, nh, nl, stray);
    check_eq("recover_pattern", 32'(stray), 32'd0);
    check_eq("recover_low", 32'(nl), 32'd16);

    // Reset mid-operation clears outputs on the next edge.
    rst = 1'b1;
    @(negedge clk);
    check_eq("mid_reset_off", 32'(gates), 32'd0);
    rst = 1'b0;

    // Random Hall/duty/reset run for the shoot-through monitor.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(7) == 0) set_hall(3'($urandom_range(7)));
      if ($urandom_range(19) == 0) bus.d = 4'($urandom_range(15));
      rst = ($urandom_range(49) == 0);
      @(negedge clk);
    end
    rst = 1'b0;
    check_eq("no_shoot_through", 32'(n_shoot), 32'd0);
    check_eq("one_hi_one_lo", 32'(n_multi), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
